request_debouncer: RTL and testbench

REQUEST_DEBOUNCER -- requirements
Module: request_debouncer

---
 rtl/request_debouncer.sv | 164 ++++++++++++++++
 tb/tb_request_debouncer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/request_debouncer.sv
// ---------------------------------------------------------------------------
// request_debouncer
//
// Turns a raw, bouncing pushbutton/sensor level into a clean debounced level
// for the traffic-light FSM, and latches a pending pedestrian request until
// the light controller acknowledges it.
//
// Parameters
//   DB_CYCLES  : consecutive stable synchronized samples needed before a level
//                change is accepted (2..255).
//   INIT_LEVEL : debounced level (and synchronizer contents) after reset.
//
// Ports
//   clk_i       in   system clock, all registers on the rising edge
//   rst_i       in   asynchronous, active-high reset
//   btn_i       in   raw level, asynchronous to clk_i, may bounce
//   ack_i       in   request-served strobe from the light controller
//   x_o         out  debounced level
//   rise_o      out  one-cycle pulse, first cycle x_o shows a 0->1 change
//   fall_o      out  one-cycle pulse, first cycle x_o shows a 1->0 change
//   req_o       out  latched pending request
//   overrun_o   out  one-cycle pulse: press accepted while req_o already set
//   press_cnt_o out  saturating count of accepted presses
//
// Handshake: req_o is set by an accepted press and cleared by ack_i = 1 on an
// edge without an accepted press. ack_i is a level sampled every edge; while
// req_o = 0 it is simply ignored. A press that lands on the same edge as
// ack_i wins, so the request stays set. No more than one request is held.
// ---------------------------------------------------------------------------
module request_debouncer #(
    parameter int unsigned DB_CYCLES  = 16,
    parameter logic        INIT_LEVEL = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_i,
    input  logic       ack_i,
    output logic       x_o,
    output logic       rise_o,
    output logic       fall_o,
    output logic       req_o,
    output logic       overrun_o,
    output logic [7:0] press_cnt_o
);

    // Counter is wide enough to hold DB_CYCLES-1; never narrower than 1 bit.
    localparam int unsigned CNT_W = ($clog2(DB_CYCLES) < 1) ? 1 : $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_x;
    logic             r_rise;
    logic             r_fall;
    logic             r_req;
    logic             r_overrun;
    logic [7:0]       r_press_cnt;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic w_differs;   // synchronized input disagrees with debounced level
    logic w_accept;    // this edge completes DB_CYCLES differing samples
    logic w_rise_evt;  // accepted change is 0->1
    logic w_fall_evt;  // accepted change is 1->0

    assign w_differs  = (r_sync2 != r_x);
    assign w_accept   = w_differs && (r_cnt == CNT_MAX);
    assign w_rise_evt = w_accept && r_sync2;
    assign w_fall_evt = w_accept && !r_sync2;

    // ------------------------------------------------------------------
    // Two-flop synchronizer. Reset to INIT_LEVEL so that a button already
    // at INIT_LEVEL after reset produces no spurious debounce activity.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= INIT_LEVEL;
            r_sync2 <= INIT_LEVEL;
        end else begin
            r_sync1 <= btn_i;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Stability counter and debounced level.
    // Any sample that agrees with x_o restarts the count, so a glitch
    // shorter than DB_CYCLES samples can never be accepted. The counter
    // holds at CNT_MAX for only one edge: that edge performs the load.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_x   <= INIT_LEVEL;
        end else if (!w_differs) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_x   <= r_sync2;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Edge pulses: registered on the same edge as the x_o load, so they
    // are high exactly in the first cycle x_o shows its new value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_rise_evt;
            r_fall <= w_fall_evt;
        end
    end

    // ------------------------------------------------------------------
    // Request latch and overrun flag. The new press has priority over a
    // coincident ack; overrun only fires when the previous request is
    // still outstanding and not being served on this very edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_rise_evt && r_req && !ack_i;
            if (w_rise_evt) begin
                r_req <= 1'b1;
            end else if (ack_i) begin
                r_req <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating press counter, updated together with rise_o.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_press_cnt <= 8'd0;
        end else if (w_rise_evt && (r_press_cnt != 8'hFF)) begin
            r_press_cnt <= r_press_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign x_o         = r_x;
    assign rise_o      = r_rise;
    assign fall_o      = r_fall;
    assign req_o       = r_req;
    assign overrun_o   = r_overrun;
    assign press_cnt_o = r_press_cnt;

endmodule

// File: tb/tb_request_debouncer.sv
// ---------------------------------------------------------------------------
// tb_request_debouncer
//
// Directed stimulus for request_debouncer with DB_CYCLES = 4, INIT_LEVEL = 0.
// A behavioural model tracks, per clock edge, the raw sample taken two edges
// earlier and how many consecutive such samples have disagreed with the
// debounced level; the DB_CYCLES-th disagreeing sample flips the level.
// Every falling edge compares all DUT outputs with that model; hand-computed
// literal checks at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_request_debouncer;

  localparam int DB = 4;

  // ------------------------------------------------------------------
  // Clock / reset / DUT
  // ------------------------------------------------------------------
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       btn_i;
  logic       ack_i;
  logic       x_o;
  logic       rise_o;
  logic       fall_o;
  logic       req_o;
  logic       overrun_o;
  logic [7:0] press_cnt_o;

  initial forever #5 clk_i = ~clk_i;

  request_debouncer #(
    .DB_CYCLES  (DB),
    .INIT_LEVEL (1'b0)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .btn_i       (btn_i),
    .ack_i       (ack_i),
    .x_o         (x_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .req_o       (req_o),
    .overrun_o   (overrun_o),
    .press_cnt_o (press_cnt_o)
  );

  // ------------------------------------------------------------------
  // Behavioural model
  // ------------------------------------------------------------------
  typedef struct packed {
    logic [1:0] dly;   // dly[0]: sample from last edge, dly[1]: two edges ago
    logic [8:0] run;   // consecutive disagreeing delayed samples so far
    logic       x;
    logic       rise;
    logic       fall;
    logic       req;
    logic       ovr;
    logic [7:0] cnt;
  } mstate_t;

  localparam mstate_t M_RESET = '{dly: 2'b00, run: 9'd0, x: 1'b0, rise: 1'b0,
                                  fall: 1'b0, req: 1'b0, ovr: 1'b0, cnt: 8'd0};

  mstate_t m = M_RESET;

  function automatic mstate_t model_next(mstate_t s, logic btn, logic ack);
    mstate_t n;
    logic    seen;
    n      = s;
    seen   = s.dly[1];
    n.dly  = {s.dly[0], btn};
    n.rise = 1'b0;
    n.fall = 1'b0;
    n.ovr  = 1'b0;
    if (seen == s.x) begin
      n.run = 9'd0;
    end else if (s.run + 9'd1 == 9'(DB)) begin
      n.x    = seen;
      n.run  = 9'd0;
      n.rise = seen;
      n.fall = !seen;
    end else begin
      n.run = s.run + 9'd1;
    end
    if (n.rise) begin
      n.ovr = s.req && !ack;
      n.req = 1'b1;
      n.cnt = (s.cnt == 8'hFF) ? 8'hFF : s.cnt + 8'd1;
    end else if (ack) begin
      n.req = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) m <= M_RESET;
    else       m <= model_next(m, btn_i, ack_i);
  end

  // ------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle compare against the model.
  always @(negedge clk_i) begin
    chk1("model_x", x_o, m.x);
    chk1("model_rise", rise_o, m.rise);
    chk1("model_fall", fall_o, m.fall);
    chk1("model_req", req_o, m.req);
    chk1("model_overrun", overrun_o, m.ovr);
    chk8("model_cnt", press_cnt_o, m.cnt);
  end

  // ------------------------------------------------------------------
  // Driver tasks (inputs change on falling edges)
  // ------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_x"}, x_o, 1'b0);
    chk1({tag, "_rise"}, rise_o, 1'b0);
    chk1({tag, "_fall"}, fall_o, 1'b0);
    chk1({tag, "_req"}, req_o, 1'b0);
    chk1({tag, "_ovr"}, overrun_o, 1'b0);
    chk8({tag, "_cnt"}, press_cnt_o, 8'd0);
  endtask

  // Press and hold; x_o must change on the 6th edge after btn_i goes high.
  task automatic press(input logic exp_ovr, input logic ack_on_rise);
    btn_i = 1'b1;
    cyc(DB + 1);
    chk1("press_before_accept_x", x_o, 1'b0);
    if (ack_on_rise) ack_i = 1'b1;
    cyc(1);
    ack_i = 1'b0;
    chk1("press_accept_x", x_o, 1'b1);
    chk1("press_rise", rise_o, 1'b1);
    chk1("press_no_fall", fall_o, 1'b0);
    chk1("press_req", req_o, 1'b1);
    chk1("press_ovr", overrun_o, exp_ovr);
    cyc(1);
    chk1("press_rise_single", rise_o, 1'b0);
    chk1("press_ovr_single", overrun_o, 1'b0);
    cyc(12);
  endtask

  task automatic release_btn();
    btn_i = 1'b0;
    cyc(DB + 1);
    chk1("release_before_accept_x", x_o, 1'b1);
    cyc(1);
    chk1("release_accept_x", x_o, 1'b0);
    chk1("release_fall", fall_o, 1'b1);
    chk1("release_no_rise", rise_o, 1'b0);
    cyc(1);
    chk1("release_fall_single", fall_o, 1'b0);
    cyc(2);
  endtask

  task automatic quick_press();
    btn_i = 1'b1;
    cyc(DB + 3);
    btn_i = 1'b0;
    cyc(DB + 3);
  endtask

  // ------------------------------------------------------------------
  // Directed sequence
  // ------------------------------------------------------------------
  logic bounce_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_i = 1'b1;
    btn_i = 1'b0;
    ack_i = 1'b0;
    cyc(2);
    chk_all_zero("reset");
    rst_i = 1'b0;
    cyc(2);

    // Bounce: 3-sample runs never reach the 4-sample threshold.
    foreach (bounce_pat[i]) begin
      btn_i = bounce_pat[i];
      cyc(3);
    end
    btn_i = 1'b0;
    cyc(10);
    chk1("bounce_x", x_o, 1'b0);
    chk8("bounce_cnt", press_cnt_o, 8'd0);

    // Clean press.
    press(1'b0, 1'b0);
    chk8("clean_cnt", press_cnt_o, 8'd1);
    release_btn();
    chk1("clean_req_held", req_o, 1'b1);

    // Handshake: ack clears; ack while idle ignored; ack on rise edge loses.
    ack_i = 1'b1;
    cyc(1);
    ack_i = 1'b0;
    chk1("ack_clears_req", req_o, 1'b0);
    ack_i = 1'b1;
    cyc(1);
    ack_i = 1'b0;
    chk1("idle_ack_ignored", req_o, 1'b0);
    press(1'b0, 1'b1);
    chk1("ack_on_rise_req", req_o, 1'b1);
    chk8("handshake_cnt", press_cnt_o, 8'd2);
    release_btn();

    // Overrun: two presses with no ack in between.
    ack_i = 1'b1;
    cyc(1);
    ack_i = 1'b0;
    chk1("pre_overrun_req", req_o, 1'b0);
    press(1'b0, 1'b0);
    release_btn();
    press(1'b1, 1'b0);
    chk1("overrun_req", req_o, 1'b1);
    chk8("overrun_cnt", press_cnt_o, 8'd4);
    release_btn();

    // Reset in the middle of a debounce, button kept high afterwards.
    btn_i = 1'b1;
    cyc(3);
    #2 rst_i = 1'b1;
    #1 chk_all_zero("async_reset");
    cyc(1);
    cyc(1);
    rst_i = 1'b0;
    cyc(DB + 1);
    chk1("post_reset_before_accept_x", x_o, 1'b0);
    chk1("post_reset_no_rise", rise_o, 1'b0);
    cyc(1);
    chk1("post_reset_x", x_o, 1'b1);
    chk1("post_reset_rise", rise_o, 1'b1);
    chk8("post_reset_cnt", press_cnt_o, 8'd1);
    btn_i = 1'b0;
    cyc(DB + 4);

    // Saturation: count from 1 past 255 and hold there.
    for (int k = 0; k < 260; k++) quick_press();
    chk8("sat_cnt", press_cnt_o, 8'hFF);
    press(1'b1, 1'b0);
    chk8("sat_hold_cnt", press_cnt_o, 8'hFF);
    release_btn();

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
